vga_timing: RTL and testbench
=============================

Name: vga_timing

Overview:
- Generates 640x480@60 VGA raster timing from the 25 MHz pixel clock.
- Drives the pixel/line/frame strobes that step the composer's counters.
- Takes the palette-resolved 12-bit RGB for each pixel and emits it with aligned, blanked HSYNC/VSYNC to the VGA connector.
- Sits upstream of the composer for strobes and downstream of the palette for pixel data. Active only when display mode is VGA.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_DELAY, 2, clocks from strobe/counter cycle to matching RGB on pins; legal range 1..8

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  25 MHz pixel clock
- enable  in  1  high when display_mode == 1 (VGA)
- palette_rgb  in  12  {R[3:0],G[3:0],B[3:0]} from palette, valid PIPE_DELAY-1 clocks after the pixel's next_pixel cycle
- next_frame  out  1  one-clock strobe at end of frame
- next_line  out  1  one-clock strobe at end of every line
- next_pixel  out  1  high in every active-pixel cycle
- current_field  out  1  constant 0 (progressive)
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hsync  out  1  negative-polarity hsync
- vga_vsync  out  1  negative-polarity vsync

Behaviour:
- Counters:
  - h_cnt is 10 bits, range 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800).
  - v_cnt is 10 bits, range 0..V_TOTAL-1, where V_TOTAL = sum of the V parameters (525).
  - h_cnt increments every clk while enable is high. It wraps to 0 after H_TOTAL-1; v_cnt increments on that wrap. v_cnt wraps to 0 after V_TOTAL-1.
- Decodes (combinational from the counters):
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hs_n = !(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC))
  - vs_n = !(v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC))
- Strobes are combinational from the counters, gated by enable:
  - next_pixel = active
  - next_line = (h_cnt == H_TOTAL-1)
  - next_frame = next_line && (v_cnt == V_TOTAL-1)
  - next_line and next_frame coincide on the final clock of a frame. Both pulse on every line/frame, including blanking.
- Alignment pipeline:
  - hs_n and vs_n pass through a PIPE_DELAY-stage shift register. Stage PIPE_DELAY drives vga_hsync/vga_vsync directly from a flop.
  - active passes through a PIPE_DELAY-1 stage shift register (a wire when PIPE_DELAY = 1) to form active_d.
  - Output register: {vga_r,vga_g,vga_b} <= active_d ? palette_rgb : 12'h000.
  - Net effect: counter state in cycle N appears on all pins in cycle N+PIPE_DELAY. palette_rgb is sampled in cycle N+PIPE_DELAY-1.
- Reset (async) values:
  - Counters 0.
  - All shift-register stages: sync stages 1, active stages 0.
  - vga_hsync = vga_vsync = 1, RGB = 0.
  - Strobes 0, because enable is assumed low out of reset; strobes are gated anyway.
- enable low:
  - On the next edge, counters load 0 and all pipeline stages load their reset values.
  - Strobes are forced 0 combinationally.
  - Pins go idle (syncs high, RGB 0) one clock after enable falls, regardless of PIPE_DELAY. No partial lines are flushed out.
- enable rising:
  - The first enabled cycle has h_cnt = v_cnt = 0, so next_pixel is high immediately.
  - The first valid RGB appears PIPE_DELAY cycles later.
  - The composer expects next_frame before real content; the first frame after enable is allowed to show stale scaling state.
- Reset mid-frame: takes effect asynchronously; the behaviour is identical to power-up.
- current_field is tied 0, so the composer never takes interlaced paths.

Test Plan:
- Reset, enable low for 100 clks -> vga_hsync = vga_vsync = 1, RGB = 0, all strobes 0 throughout.
- Enable rises, palette_rgb = 12'hFFF constant, PIPE_DELAY = 2 -> line 0:
  - next_pixel high for exactly 640 consecutive clks starting in the first enabled cycle.
  - next_line high only at the 800th clk.
  - RGB = FFF for 640 clks starting 2 clks after enable, then 0 for 160 clks.
- hsync position, PIPE_DELAY = 2 -> vga_hsync falls in the cycle where h_cnt = 658 and rises where h_cnt = 754 (96 clks low).
- Full frame -> next_line count = 525 per frame; next_frame spacing = 420000 clks; next_frame coincident with a next_line.
- vsync -> vga_vsync low for exactly 1600 clks, starting at h_cnt = 2 of line 490 (PIPE_DELAY = 2).
- Enable dropped at v = 100, h = 300 -> next edge: strobes 0, syncs 1, RGB 0.
  - Re-enable -> counting restarts at h = 0, v = 0.
  - Repeat with PIPE_DELAY = 1 and 5 and check alignment scales with PIPE_DELAY.

Source files
------------

// File: rtl/vga_timing_if.sv
// Signal bundle for the VGA timing block: palette pixel data in, composer strobes and
// connector pins out. The master side is the timing generator itself.
interface vga_timing_if;
  logic        enable;
  logic [11:0] palette_rgb;
  logic        next_frame;
  logic        next_line;
  logic        next_pixel;
  logic        current_field;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hsync;
  logic        vga_vsync;

  modport master (
    input  enable,
    input  palette_rgb,
    output next_frame,
    output next_line,
    output next_pixel,
    output current_field,
    output vga_r,
    output vga_g,
    output vga_b,
    output vga_hsync,
    output vga_vsync
  );

  modport slave (
    output enable,
    output palette_rgb,
    input  next_frame,
    input  next_line,
    input  next_pixel,
    input  current_field,
    input  vga_r,
    input  vga_g,
    input  vga_b,
    input  vga_hsync,
    input  vga_vsync
  );
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 raster timing generator: counter strobes for the composer and
// delay-matched, blanked RGB plus negative-polarity syncs for the connector.
module vga_timing #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HActEnd  = 10'(H_ACTIVE);
  localparam logic [9:0] HSyncBeg = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VActEnd  = 10'(V_ACTIVE);
  localparam logic [9:0] VSyncBeg = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);

  logic [9:0]            r_h_cnt;
  logic [9:0]            r_v_cnt;
  logic [PIPE_DELAY-1:0] r_hs_pipe;
  logic [PIPE_DELAY-1:0] r_vs_pipe;
  logic [11:0]           r_rgb;

  logic w_active;
  logic w_active_d;
  logic w_hs_n;
  logic w_vs_n;
  logic w_h_last;
  logic w_v_last;

  // Raster counters; disabling parks them at the origin so re-enable restarts a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!vga.enable) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  always_comb begin
    w_h_last = (r_h_cnt == HLast);
    w_v_last = (r_v_cnt == VLast);
    w_active = (r_h_cnt < HActEnd) && (r_v_cnt < VActEnd);
    w_hs_n   = !((r_h_cnt >= HSyncBeg) && (r_h_cnt < HSyncEnd));
    w_vs_n   = !((r_v_cnt >= VSyncBeg) && (r_v_cnt < VSyncEnd));
  end

  assign vga.next_pixel    = vga.enable & w_active;
  assign vga.next_line     = vga.enable & w_h_last;
  assign vga.next_frame    = vga.enable & w_h_last & w_v_last;
  assign vga.current_field = 1'b0;

  // Sync delay line; its last stage is the pin flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs_pipe <= '1;
      r_vs_pipe <= '1;
    end else if (!vga.enable) begin
      r_hs_pipe <= '1;
      r_vs_pipe <= '1;
    end else begin
      r_hs_pipe[0] <= w_hs_n;
      r_vs_pipe[0] <= w_vs_n;
      for (int i = 1; i < int'(PIPE_DELAY); i++) begin
        r_hs_pipe[i] <= r_hs_pipe[i-1];
        r_vs_pipe[i] <= r_vs_pipe[i-1];
      end
    end
  end

  // Active flag is one stage shorter because the RGB output register adds the last stage.
  if (PIPE_DELAY > 1) begin : g_act_pipe
    logic [PIPE_DELAY-2:0] r_act_pipe;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_act_pipe <= '0;
      end else if (!vga.enable) begin
        r_act_pipe <= '0;
      end else begin
        r_act_pipe[0] <= w_active;
        for (int i = 1; i < int'(PIPE_DELAY) - 1; i++) begin
          r_act_pipe[i] <= r_act_pipe[i-1];
        end
      end
    end

    assign w_active_d = r_act_pipe[PIPE_DELAY-2];
  end else begin : g_act_wire
    assign w_active_d = w_active;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb <= '0;
    end else if (!vga.enable) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_active_d ? vga.palette_rgb : 12'h000;
    end
  end

  assign vga.vga_r     = r_rgb[11:8];
  assign vga.vga_g     = r_rgb[7:4];
  assign vga.vga_b     = r_rgb[3:0];
  assign vga.vga_hsync = r_hs_pipe[PIPE_DELAY-1];
  assign vga.vga_vsync = r_vs_pipe[PIPE_DELAY-1];

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: four instances (full timing at delay 2, short-frame at delays 1/2/5)
// checked every cycle against a raster model, plus hand-computed directed checks.
module tb_vga_timing;
  localparam int NI  = 4;
  localparam int HT  = 800;
  localparam int HA  = 640;
  localparam int HSS = 656;
  localparam int HSE = 752;

  int va  [NI] = '{480, 6, 6, 6};
  int vfp [NI] = '{10, 2, 2, 2};
  int vsw [NI] = '{2, 2, 2, 2};
  int vbp [NI] = '{33, 3, 3, 3};
  int dl  [NI] = '{2, 1, 2, 5};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] pal = 12'h000;

  always #20 clk = ~clk;

  vga_timing_if if0 ();
  vga_timing_if if1 ();
  vga_timing_if if2 ();
  vga_timing_if if3 ();

  assign if0.enable = enable;
  assign if1.enable = enable;
  assign if2.enable = enable;
  assign if3.enable = enable;
  assign if0.palette_rgb = pal;
  assign if1.palette_rgb = pal;
  assign if2.palette_rgb = pal;
  assign if3.palette_rgb = pal;

  vga_timing #(.PIPE_DELAY(2)) u_full (.clk(clk), .rst(rst), .vga(if0));
  vga_timing #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(1))
    u_d1 (.clk(clk), .rst(rst), .vga(if1));
  vga_timing #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(2))
    u_d2 (.clk(clk), .rst(rst), .vga(if2));
  vga_timing #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(5))
    u_d5 (.clk(clk), .rst(rst), .vga(if3));

  logic [NI-1:0] o_pix, o_line, o_frame, o_hs, o_vs, o_fld;
  logic [11:0]   o_rgb [NI];

  assign o_pix   = {if3.next_pixel, if2.next_pixel, if1.next_pixel, if0.next_pixel};
  assign o_line  = {if3.next_line, if2.next_line, if1.next_line, if0.next_line};
  assign o_frame = {if3.next_frame, if2.next_frame, if1.next_frame, if0.next_frame};
  assign o_hs    = {if3.vga_hsync, if2.vga_hsync, if1.vga_hsync, if0.vga_hsync};
  assign o_vs    = {if3.vga_vsync, if2.vga_vsync, if1.vga_vsync, if0.vga_vsync};
  assign o_fld   = {if3.current_field, if2.current_field, if1.current_field, if0.current_field};
  assign o_rgb[0] = {if0.vga_r, if0.vga_g, if0.vga_b};
  assign o_rgb[1] = {if1.vga_r, if1.vga_g, if1.vga_b};
  assign o_rgb[2] = {if2.vga_r, if2.vga_g, if2.vga_b};
  assign o_rgb[3] = {if3.vga_r, if3.vga_g, if3.vga_b};

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Model history: per cycle, whether the block was enabled, how many consecutive enabled
  // cycles preceded it (its raster position), and the palette value offered.
  bit          en_h  [16];
  int          k_h   [16];
  logic [11:0] pal_h [16];
  int          t_cyc = 0;

  task automatic model_check(input int i, input int t);
    int ix, k, h, v, vt, d, k0, h0, v0, e_hs, e_vs, e_rgb, ep, el, ef;
    bit ok;
    ix = t % 16;
    vt = va[i] + vfp[i] + vsw[i] + vbp[i];
    k  = k_h[ix];
    h  = k % HT;
    v  = (k / HT) % vt;
    ep = int'(en_h[ix] && h < HA && v < va[i]);
    el = int'(en_h[ix] && h == HT - 1);
    ef = int'(el == 1 && v == vt - 1);
    d  = dl[i];
    ok = !rst && (t >= d);
    for (int j = 1; j <= d; j++) if (ok && !en_h[(t - j) % 16]) ok = 1'b0;
    e_hs = 1;
    e_vs = 1;
    e_rgb = 0;
    if (ok) begin
      k0 = k_h[(t - d) % 16];
      h0 = k0 % HT;
      v0 = (k0 / HT) % vt;
      e_hs = int'(!(h0 >= HSS && h0 < HSE));
      e_vs = int'(!(v0 >= va[i] + vfp[i] && v0 < va[i] + vfp[i] + vsw[i]));
      if (h0 < HA && v0 < va[i]) e_rgb = int'(pal_h[(t - 1) % 16]);
    end
    check($sformatf("model_pix[%0d]", i), int'(o_pix[i]), ep);
    check($sformatf("model_line[%0d]", i), int'(o_line[i]), el);
    check($sformatf("model_frame[%0d]", i), int'(o_frame[i]), ef);
    check($sformatf("model_field[%0d]", i), int'(o_fld[i]), 0);
    check($sformatf("model_hsync[%0d]", i), int'(o_hs[i]), e_hs);
    check($sformatf("model_vsync[%0d]", i), int'(o_vs[i]), e_vs);
    check($sformatf("model_rgb[%0d]", i), int'(o_rgb[i]), e_rgb);
  endtask

  initial begin
    forever begin
      int ix, pv;
      bit en_now;
      @(negedge clk);
      ix = t_cyc % 16;
      pv = (t_cyc + 15) % 16;
      en_now = enable && !rst;
      en_h[ix] = en_now;
      k_h[ix] = (en_now && t_cyc > 0 && en_h[pv]) ? k_h[pv] + 1 : 0;
      pal_h[ix] = pal;
      for (int i = 0; i < NI; i++) model_check(i, t_cyc);
      t_cyc++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vs_fall, vs_low, fr1, fr2, lines;
    vs_fall = -1;
    vs_low = 0;
    fr1 = -1;
    fr2 = -1;
    lines = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Disabled after reset: idle pins, no strobes.
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      check("idle_hsync", int'(if0.vga_hsync), 1);
      check("idle_vsync", int'(if0.vga_vsync), 1);
      check("idle_rgb", int'(o_rgb[0]), 0);
      check("idle_strobes", int'({if0.next_pixel, if0.next_line, if0.next_frame}), 0);
      next_cycle();
    end

    // Two short frames; line 0 checked against hand-computed positions.
    enable = 1'b1;
    for (int j = 0; j < 20810; j++) begin
      pal = (j < 800) ? 12'hFFF : 12'((j * 37) ^ (j >> 3));
      @(negedge clk);
      if (j < 800) begin
        check("l0_pixel", int'(if0.next_pixel), int'(j < 640));
        check("l0_line", int'(if0.next_line), int'(j == 799));
        check("l0_rgb_d2", int'(o_rgb[0]), (j >= 2 && j < 642) ? 'hFFF : 0);
        check("l0_rgb_d1", int'(o_rgb[1]), (j >= 1 && j < 641) ? 'hFFF : 0);
        check("l0_rgb_d5", int'(o_rgb[3]), (j >= 5 && j < 645) ? 'hFFF : 0);
        check("l0_hsync_d2", int'(if0.vga_hsync), int'(!(j >= 658 && j < 754)));
        check("l0_hsync_d1", int'(if1.vga_hsync), int'(!(j >= 657 && j < 753)));
        check("l0_hsync_d5", int'(if3.vga_hsync), int'(!(j >= 661 && j < 757)));
      end
      if (!o_vs[2]) begin
        if (vs_fall < 0) vs_fall = j;
        if (j < 10400) vs_low++;
      end
      if (o_line[2] && j < 10400) lines++;
      if (o_frame[2]) begin
        if (fr1 < 0) fr1 = j;
        else if (fr2 < 0) fr2 = j;
        check("frame_with_line", int'(o_line[2]), 1);
      end
      next_cycle();
    end
    check("vsync_start", vs_fall, 8 * 800 + 2);
    check("vsync_len", vs_low, 1600);
    check("frame1_pos", fr1, 10399);
    check("frame_spacing", fr2 - fr1, 10400);
    check("lines_per_frame", lines, 13);

    // Run to line 5, pixel 300 of the short frame, then drop enable there.
    pal = 12'hA5C;
    for (int j = 20810; j < 25100; j++) begin
      @(negedge clk);
      next_cycle();
    end
    enable = 1'b0;
    @(negedge clk);
    check("drop_strobes", int'({o_pix, o_line, o_frame}), 0);
    next_cycle();
    @(negedge clk);
    check("drop_hsync", int'(o_hs), 'hF);
    check("drop_vsync", int'(o_vs), 'hF);
    for (int i = 0; i < NI; i++) check($sformatf("drop_rgb[%0d]", i), int'(o_rgb[i]), 0);
    for (int j = 0; j < 9; j++) next_cycle();

    // Re-enable restarts at the origin; RGB latency follows PIPE_DELAY.
    next_cycle();
    enable = 1'b1;
    for (int r = 0; r < 800; r++) begin
      @(negedge clk);
      if (r == 0) check("reen_pixel", int'(o_pix), 'hF);
      check("reen_line", int'(if0.next_line), int'(r == 799));
      for (int i = 0; i < NI; i++)
        check($sformatf("reen_rgb[%0d]", i), int'(o_rgb[i]),
              (r >= dl[i] && r < 640 + dl[i]) ? 'hA5C : 0);
      next_cycle();
    end

    // Mid-frame reset behaves like power-up.
    for (int j = 0; j < 500; j++) next_cycle();
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check("rst_hsync", int'(o_hs), 'hF);
    check("rst_vsync", int'(o_vs), 'hF);
    check("rst_rgb", int'(o_rgb[3]), 0);
    for (int j = 0; j < 3; j++) next_cycle();
    rst = 1'b0;
    enable = 1'b1;
    for (int r = 0; r < 800; r++) begin
      @(negedge clk);
      check("rst_restart_pix", int'(if0.next_pixel), int'(r < 640));
      check("rst_restart_line", int'(if0.next_line), int'(r == 799));
      next_cycle();
    end

    enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
